// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   - Access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 is illegal)
//   - FSM state encoding, exported on the controller's debug port
//   - byte_en()    : lane enables for a given size and byte offset
//   - misaligned() : alignment check for a given size and effective address
//   - lane_data()  : replicate right-justified store data across the lanes
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << ofs;
            SZ_HALF: byte_en = 4'b0011 << ofs;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Only the two low address bits matter for alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ea);
        case (size)
            SZ_HALF: misaligned = ea[0];
            SZ_WORD: misaligned = (ea != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Replicating the data means the memory can take whichever lanes
    // byte_en selects without any further shifting.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] sv);
        case (size)
            SZ_BYTE: lane_data = {4{sv[7:0]}};
            SZ_HALF: lane_data = {2{sv[15:0]}};
            default: lane_data = sv;
        endcase
    endfunction

endpackage

// File: rtl/load_store_ctrl_if.sv
// Bus bundle between the execute stage, the load/store controller and the
// data memory.
//   Request  : req_valid/req_ready handshake plus op fields (store flag,
//              size, unsigned, read1, immediate, store_value).
//   Response : rsp_valid one-cycle pulse with rsp_data and rsp_fault.
//   Memory   : dataAddr_reg, mem_read_en, mem_write_en, mem_byte_en,
//              mem_wdata out; readData_reg, mem_ack in.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds req_valid and its fields
// until then. rsp_valid has no ready -- the consumer must take it in the
// cycle it is shown.
// modport master : the controller (owns the memory port)
// modport slave  : the environment (execute stage and memory)
interface load_store_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] read1;
    logic [31:0] immediate;
    logic [31:0] store_value;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [31:0] dataAddr_reg;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] readData_reg;
    logic        mem_ack;

    modport master (
        input  req_valid, req_is_store, req_size, req_unsigned,
               read1, immediate, store_value, readData_reg, mem_ack,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
               dataAddr_reg, mem_read_en, mem_write_en, mem_byte_en, mem_wdata
    );

    modport slave (
        output req_valid, req_is_store, req_size, req_unsigned,
               read1, immediate, store_value, readData_reg, mem_ack,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
               dataAddr_reg, mem_read_en, mem_write_en, mem_byte_en, mem_wdata
    );
endinterface

// File: rtl/load_align.sv
// Load data alignment (combinational).
//   rdata       : 32-bit word read from memory
//   ofs         : byte offset of the access within the word (ea[1:0])
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned : 1 zero-extends, 0 sign-extends
//   result      : selected lane, extended to 32 bits (0 for illegal size)
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  ofs,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{ofs, 3'b000} +: 8];
        // Half accesses are aligned, so only ea[1] picks the lane.
        half_sel = ofs[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_WORD: result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store controller: runs one memory op at a time between the execute
// stage and the data memory.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : load_store_ctrl_if.master (request, response, memory port)
//   dbg_state : current FSM state
// Flow: IDLE accepts a request and latches ea = read1 + immediate plus the
// op fields. Illegal size or misalignment goes straight to RESP with a
// fault; otherwise ACCESS holds the strobes until mem_ack or until
// TIMEOUT_CYCLES ACCESS cycles pass without one (fault). RESP pulses
// rsp_valid for one cycle. All bus outputs decode from registered state, so
// an asynchronous reset drops the strobes at once and discards the op.
module load_store_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    load_store_ctrl_if.master  bus,
    output state_t             dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t state, state_nx;

    logic [31:0]   ea_q;
    logic [31:0]   sv_q;
    logic [31:0]   data_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          store_q;
    logic          fault_q;
    logic [CW-1:0] cnt_q;

    logic [31:0] ea_in;
    logic        bad_in;
    logic        timeout;
    logic [31:0] load_result;

    assign ea_in   = bus.read1 + bus.immediate;
    assign bad_in  = (bus.req_size == SZ_BAD) || misaligned(bus.req_size, ea_in[1:0]);
    // The final ACCESS cycle still accepts an ack; only a missing ack there faults.
    assign timeout = (cnt_q == CNT_LAST) && !bus.mem_ack;
    assign dbg_state = state;

    load_align u_align (
        .rdata       (bus.readData_reg),
        .ofs         (ea_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_fault    = 1'b0;
        bus.rsp_data     = '0;
        bus.dataAddr_reg = '0;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.mem_byte_en  = '0;
        bus.mem_wdata    = '0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = bad_in ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.mem_read_en  = ~store_q;
                bus.mem_write_en = store_q;
                bus.dataAddr_reg = {ea_q[31:2], 2'b00};
                bus.mem_byte_en  = byte_en(size_q, ea_q[1:0]);
                bus.mem_wdata    = lane_data(size_q, sv_q);
                if (bus.mem_ack || timeout) state_nx = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_fault = fault_q;
                bus.rsp_data  = data_q;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea_q    <= '0;
            sv_q    <= '0;
            data_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ea_q    <= ea_in;
                        sv_q    <= bus.store_value;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        store_q <= bus.req_is_store;
                        fault_q <= bad_in;
                        data_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        data_q  <= store_q ? 32'd0 : load_result;
                        fault_q <= 1'b0;
                    end else if (timeout) begin
                        data_q  <= '0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: directed ops from the datasheet examples plus
// randomized ops, a reference model computing expected memory accesses and
// responses, a memory responder, and a monitor scoreboard.
module tb_load_store_ctrl;
    import lsu_pkg::*;

    localparam int TO = 15;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    always #5 clk = ~clk;

    load_store_ctrl_if bus ();

    load_store_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_count = 0;
    int accept_cyc = 0;
    int ack_delay = 0;
    logic [31:0] ack_rdata = '0;

    // {latency[7:0], fault, data[31:0]}
    logic [40:0] exp_q[$];
    // {rd, wr, addr[31:0], be[3:0], wdata[31:0], strobe_len[7:0]}
    logic [77:0] mem_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, need %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] ea,
                                               input logic [1:0] sz, input logic un);
        int nb;
        int sh;
        logic [31:0] mask;
        logic [31:0] v;
        nb = 1 << sz;
        if (nb == 4) return rd;
        sh = (nb == 1) ? 8 * int'(ea % 4) : 16 * int'((ea % 4) / 2);
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v = (rd >> sh) & mask;
        if (!un && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] ea);
        int nb;
        logic [3:0] m;
        nb = 1 << sz;
        m = 4'((1 << nb) - 1);
        return m << (ea % 4);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] sv);
        int nb;
        logic [31:0] w;
        nb = 1 << sz;
        w = '0;
        for (int i = 0; i < 4; i++) w[8 * i +: 8] = sv[8 * (i % nb) +: 8];
        return w;
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] r1, input logic [31:0] imm,
                         input logic [31:0] sv, input logic [31:0] rd, input int dly);
        logic [31:0] ea;
        logic        bad;
        int          nb;
        int          start;
        bit          got;
        ea = r1 + imm;
        nb = 1 << sz;
        bad = (sz == 2'b11) || ((ea % 32'(nb)) != 0);
        if (bad) begin
            exp_q.push_back({8'd1, 1'b1, 32'd0});
        end else if (dly >= TO) begin
            mem_q.push_back({~st, st, ea & 32'hFFFF_FFFC, model_be(sz, ea), model_wdata(sz, sv), 8'(TO)});
            exp_q.push_back({8'(TO + 1), 1'b1, 32'd0});
        end else begin
            mem_q.push_back({~st, st, ea & 32'hFFFF_FFFC, model_be(sz, ea), model_wdata(sz, sv), 8'(dly + 1)});
            exp_q.push_back({8'(dly + 2), 1'b0, st ? 32'd0 : model_load(rd, ea, sz, un)});
        end
        ack_delay = dly;
        ack_rdata = rd;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.read1        = r1;
        bus.immediate    = imm;
        bus.store_value  = sv;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accept_cyc = cyc;
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.read1        = $urandom;
        bus.immediate    = $urandom;
        bus.store_value  = $urandom;
        if (!got) check("accept_timeout", 0, 1);
        start = rsp_count;
        for (int i = 0; i < 60 && rsp_count == start; i++) @(negedge clk);
        if (rsp_count == start) check("response_timeout", 0, 1);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int n;
        n = 0;
        bus.mem_ack = 1'b0;
        bus.readData_reg = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_read_en || bus.mem_write_en) begin
                bus.mem_ack = (n == ack_delay);
                bus.readData_reg = (n == ack_delay) ? ack_rdata : $urandom;
                n++;
            end else begin
                n = 0;
                // Stray acks outside ACCESS must be ignored.
                bus.mem_ack = ($urandom_range(0, 3) == 0);
                bus.readData_reg = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [77:0] cur;
    logic [40:0] e;
    logic        act = 1'b0;
    int          slen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if ((bus.mem_read_en || bus.mem_write_en) && !act) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    cur = mem_q.pop_front();
                    act = 1'b1;
                    slen = 0;
                end
            end
            if ((bus.mem_read_en || bus.mem_write_en) && act) begin
                check("strobe_kind", {bus.mem_read_en, bus.mem_write_en}, cur[77:76]);
                check("ready_in_access", bus.req_ready, 0);
                check("mem_addr", bus.dataAddr_reg, cur[75:44]);
                check("mem_byte_en", bus.mem_byte_en, cur[43:40]);
                if (cur[76]) check("mem_wdata", bus.mem_wdata, cur[39:8]);
                slen++;
            end else if (act) begin
                check("strobe_len", slen, cur[7:0]);
                act = 1'b0;
            end
            if (bus.rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_fault", bus.rsp_fault, e[32]);
                    check("rsp_data", bus.rsp_data, e[31:0]);
                    check("rsp_latency", cyc - accept_cyc, e[40:33]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  sz;
        logic [31:0] ea;
        logic [31:0] r1;
        int          r;
        int          dly;
        rst = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.read1        = '0;
        bus.immediate    = '0;
        bus.store_value  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bus.req_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_rsp_fault", bus.rsp_fault, 0);
        check("reset_strobes", {bus.mem_read_en, bus.mem_write_en}, 0);
        check("reset_byte_en", bus.mem_byte_en, 0);
        check("reset_addr", bus.dataAddr_reg, 0);
        check("reset_wdata", bus.mem_wdata, 0);
        check("reset_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Datasheet examples
        do_op(1'b0, SZ_WORD, 1'b0, 32'h5C, 32'd4, 32'h0, 32'h0000_0003, 0);
        do_op(1'b0, SZ_BYTE, 1'b0, 32'h60, 32'd1, 32'h0, 32'h0000_8000, 1);
        do_op(1'b0, SZ_BYTE, 1'b1, 32'h60, 32'd1, 32'h0, 32'h0000_8000, 2);
        do_op(1'b1, SZ_HALF, 1'b0, 32'h60, 32'd2, 32'h1234_ABCD, 32'h0, 3);
        do_op(1'b0, SZ_WORD, 1'b0, 32'h5C, 32'd2, 32'h0, 32'h0, 0);
        do_op(1'b0, SZ_WORD, 1'b0, 32'h100, 32'd0, 32'h0, 32'hDEAD_BEEF, 100);
        // Ack on the very last permitted ACCESS cycle still completes.
        do_op(1'b0, SZ_HALF, 1'b0, 32'h200, 32'd2, 32'h0, 32'h8001_7FFF, TO - 1);
        // Illegal size and a wrapping address sum.
        do_op(1'b1, SZ_BAD, 1'b0, 32'h40, 32'd0, 32'h5555_5555, 32'h0, 0);
        do_op(1'b1, SZ_BYTE, 1'b0, 32'hFFFF_FFFF, 32'd4, 32'h0000_00A5, 32'h0, 0);

        // Reset in the second ACCESS cycle of a store.
        ack_delay = 100;
        mem_q.push_back({1'b0, 1'b1, 32'h80, 4'b1111, 32'h0BAD_F00D, 8'd0});
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.read1        = 32'h80;
        bus.immediate    = 32'h0;
        bus.store_value  = 32'h0BAD_F00D;
        @(negedge clk);
        check("rst_case_accept", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_write_en", bus.mem_write_en, 0);
        check("rst_async_byte_en", bus.mem_byte_en, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_q.delete();
        @(negedge clk);
        check("rst_release_ready", bus.req_ready, 1);
        repeat (5) @(posedge clk);
        do_op(1'b1, SZ_WORD, 1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 32'h0, 1);

        // Randomized ops
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 15);
            sz = (r < 5) ? SZ_BYTE : (r < 10) ? SZ_HALF : (r < 15) ? SZ_WORD : SZ_BAD;
            ea = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == SZ_HALF) ea = ea & 32'hFFFF_FFFE;
                if (sz == SZ_WORD) ea = ea & 32'hFFFF_FFFC;
            end
            r1 = $urandom;
            dly = ($urandom_range(0, 19) == 0) ? TO + int'($urandom_range(0, 5)) : int'($urandom_range(0, 4));
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), r1, ea - r1,
                  $urandom, $urandom, dly);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
